ram_byte_adapter: RTL and testbench

- Sits between the processor's load/store path and the 8-bit-wide data RAM (`RamD`).
- Accepts one 32-bit load or store request at a time over a valid/ready handshake.
- Serialises the request into 1, 2 or 4 single-byte RAM accesses, little-endian, at consecutive byte addresses.
- For loads, reassembles the returned bytes into a zero-extended 32-bit response.

---
 rtl/ram_byte_adapter_if.sv | 26 ++
 rtl/ram_byte_adapter.sv | 144 ++++++++++++++
 tb/tb_ram_byte_adapter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_byte_adapter_if.sv
// Request/response bundle between the load/store path and ram_byte_adapter.
// The master issues one request at a time; the slave answers with a one-cycle
// response pulse carrying zero-extended load data.
interface ram_byte_adapter_if #(
  parameter int ADDR_W = 8,
  parameter int NBYTES = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic [ADDR_W-1:0]     req_addr;
  logic [8*NBYTES-1:0]   req_wdata;
  logic                  rsp_valid;
  logic [8*NBYTES-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/ram_byte_adapter.sv
// Serialises one word/halfword/byte load or store into little-endian
// single-byte accesses on an 8-bit synchronous RAM and reassembles load data.
// All outputs are registered; idx_r counts the bytes already presented.
module ram_byte_adapter #(
  parameter int ADDR_W = 8,
  parameter int NBYTES = 4
) (
  input  logic              clock,
  input  logic              reset,
  ram_byte_adapter_if.slave bus,
  output logic [ADDR_W-1:0] ram_address,
  output logic [31:0]       ram_data,
  output logic              ram_wren,
  input  logic [7:0]        ram_q
);
  localparam int DATA_W = 8 * NBYTES;
  localparam int IDX_W  = $clog2(NBYTES + 1);
  localparam int BSEL_W = $clog2(NBYTES);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR      = 3'd1;
  localparam logic [2:0] ST_RD      = 3'd2;
  localparam logic [2:0] ST_RD_TAIL = 3'd3;
  localparam logic [2:0] ST_RSP     = 3'd4;

  // Number of byte accesses for a size code; reserved code 11 acts as a word.
  function automatic logic [IDX_W-1:0] byte_count(input logic [1:0] size);
    case (size)
      2'b00:   byte_count = IDX_W'(1);
      2'b01:   byte_count = IDX_W'(2);
      default: byte_count = IDX_W'(NBYTES);
    endcase
  endfunction

  logic [2:0]        state_r;
  logic [IDX_W-1:0]  idx_r;
  logic [IDX_W-1:0]  cnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] cap_r;
  logic              ready_r;
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_rdata_r;

  logic [BSEL_W-1:0] bsel_s;
  logic [DATA_W-1:0] cap_merge_s;
  logic [ADDR_W-1:0] next_addr_s;
  logic [7:0]        next_byte_s;

  assign bus.req_ready = ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;

  // Capture lane for ram_q (RAM answers one cycle late) and next byte to present.
  always_comb begin
    bsel_s = {BSEL_W{1'b0}};
    if (state_r == ST_RD_TAIL) begin
      bsel_s = BSEL_W'(cnt_r - IDX_W'(1));
    end else begin
      bsel_s = BSEL_W'(idx_r - IDX_W'(2));
    end
    cap_merge_s = cap_r;
    cap_merge_s[{bsel_s, 3'b000} +: 8] = ram_q;
    next_addr_s = addr_r + ADDR_W'(idx_r);
    next_byte_s = wdata_r[{BSEL_W'(idx_r), 3'b000} +: 8];
  end

  // Sequencer: accept, byte-serial write/read, read tail, one-cycle response.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      idx_r       <= {IDX_W{1'b0}};
      cnt_r       <= {IDX_W{1'b0}};
      addr_r      <= {ADDR_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      cap_r       <= {DATA_W{1'b0}};
      ready_r     <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_W{1'b0}};
      ram_address <= {ADDR_W{1'b0}};
      ram_data    <= 32'h0000_0000;
      ram_wren    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          rsp_valid_r <= 1'b0;
          if (bus.req_valid && ready_r) begin
            state_r     <= bus.req_we ? ST_WR : ST_RD;
            ready_r     <= 1'b0;
            addr_r      <= bus.req_addr;
            wdata_r     <= bus.req_wdata;
            cnt_r       <= byte_count(bus.req_size);
            cap_r       <= {DATA_W{1'b0}};
            // byte 0 goes out right away, so one byte is already issued
            idx_r       <= IDX_W'(1);
            ram_address <= bus.req_addr;
            ram_data    <= {24'h00_0000, bus.req_wdata[7:0]};
            ram_wren    <= bus.req_we;
          end
        end
        ST_WR: begin
          if (idx_r == cnt_r) begin
            state_r     <= ST_RSP;
            ram_wren    <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= {DATA_W{1'b0}};
          end else begin
            ram_address <= next_addr_s;
            ram_data    <= {24'h00_0000, next_byte_s};
            idx_r       <= idx_r + IDX_W'(1);
          end
        end
        ST_RD: begin
          if (idx_r >= IDX_W'(2)) begin
            cap_r <= cap_merge_s;
          end
          if (idx_r == cnt_r) begin
            state_r <= ST_RD_TAIL;
          end else begin
            ram_address <= next_addr_s;
            idx_r       <= idx_r + IDX_W'(1);
          end
        end
        ST_RD_TAIL: begin
          cap_r       <= cap_merge_s;
          rsp_rdata_r <= cap_merge_s;
          rsp_valid_r <= 1'b1;
          state_r     <= ST_RSP;
        end
        ST_RSP: begin
          rsp_valid_r <= 1'b0;
          ready_r     <= 1'b1;
          state_r     <= ST_IDLE;
        end
        default: begin
          state_r     <= ST_IDLE;
          ready_r     <= 1'b1;
          rsp_valid_r <= 1'b0;
          ram_wren    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ram_byte_adapter.sv
// Directed bench for ram_byte_adapter with a behavioural 256x8 synchronous RAM.
module tb_ram_byte_adapter;
  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  ram_address;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [7:0]  ram_q = 8'h00;
  logic [7:0]  mem [256] = '{default: 8'h00};
  int          tests_run = 0;
  int          tests_failed = 0;

  ram_byte_adapter_if #(.ADDR_W(8), .NBYTES(4)) bus ();

  ram_byte_adapter #(.ADDR_W(8), .NBYTES(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q)
  );

  always #5 clock = ~clock;

  // synchronous RAM: write on wren, registered read one cycle later
  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data[7:0];
    ram_q <= mem[ram_address];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // present a request before the next edge; it is accepted on that edge
  task automatic send(input logic we, input logic [1:0] size, input logic [7:0] addr,
                      input logic [31:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = size;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    tick();
    bus.req_valid = 1'b0;
    bus.req_we    = ~we;
    bus.req_addr  = 8'h99;
    bus.req_wdata = 32'h5555_5555;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    send(1'b1, 2'b10, 8'h55, 32'h1234_5678);
    tick();
    reset = 1'b0;
    tests_run++;
    if ({ram_address, ram_wren, ram_data, bus.rsp_valid, bus.req_ready, bus.rsp_rdata}
        !== {8'h00, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset_state: addr=%h wren=%b data=%h rv=%b rdy=%b rd=%h", ram_address,
               ram_wren, ram_data, bus.rsp_valid, bus.req_ready, bus.rsp_rdata);
    end
    tick();
    tests_run++;
    if (mem[8'h55] !== 8'h00 || bus.req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ignore: mem55=%h rdy=%b expected 00 1", mem[8'h55], bus.req_ready);
    end
  endtask

  task automatic test_word_store();
    logic [7:0] ea [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
    logic [7:0] ed [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send(1'b1, 2'b10, 8'h10, 32'hDEAD_BEEF);
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if ({ram_address, ram_wren, ram_data, bus.rsp_valid, bus.req_ready}
          !== {ea[k], 1'b1, 24'h0, ed[k], 1'b0, 1'b0}) begin
        tests_failed++;
        $display("FAIL wstore_byte%0d: addr=%h wren=%b data=%h rv=%b rdy=%b exp %h 1 %h 0 0",
                 k, ram_address, ram_wren, ram_data, bus.rsp_valid, bus.req_ready, ea[k], ed[k]);
      end
      tick();
    end
    tests_run++;
    if ({bus.rsp_valid, bus.req_ready, ram_wren, bus.rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL wstore_rsp: rv=%b rdy=%b wren=%b rd=%h exp 1 0 0 0", bus.rsp_valid,
               bus.req_ready, ram_wren, bus.rsp_rdata);
    end
    tick();
    tests_run++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b01 ||
        {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]} !== 32'hEFBE_ADDE) begin
      tests_failed++;
      $display("FAIL wstore_after: rv=%b rdy=%b mem=%h %h %h %h", bus.rsp_valid, bus.req_ready,
               mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]);
    end
  endtask

  task automatic test_word_load();
    logic [7:0] ea [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
    send(1'b0, 2'b10, 8'h10, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if ({ram_address, ram_wren, bus.rsp_valid, bus.req_ready} !== {ea[k], 3'b000}) begin
        tests_failed++;
        $display("FAIL wload_byte%0d: addr=%h wren=%b rv=%b rdy=%b exp %h 0 0 0", k,
                 ram_address, ram_wren, bus.rsp_valid, bus.req_ready, ea[k]);
      end
      tick();
    end
    tests_run++;
    if ({bus.rsp_valid, ram_wren} !== 2'b00) begin
      tests_failed++;
      $display("FAIL wload_tail: rv=%b wren=%b exp 0 0", bus.rsp_valid, ram_wren);
    end
    tick();
    tests_run++;
    if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      tests_failed++;
      $display("FAIL wload_rsp: rv=%b rd=%h exp 1 deadbeef", bus.rsp_valid, bus.rsp_rdata);
    end
    tick();
    tests_run++;
    if ({bus.rsp_valid, bus.req_ready, bus.rsp_rdata} !== {2'b01, 32'hDEAD_BEEF}) begin
      tests_failed++;
      $display("FAIL wload_hold: rv=%b rdy=%b rd=%h exp 0 1 deadbeef", bus.rsp_valid,
               bus.req_ready, bus.rsp_rdata);
    end
  endtask

  task automatic test_half_store();
    send(1'b1, 2'b01, 8'h20, 32'hAAAA_1234);
    tests_run++;
    if ({ram_address, ram_wren, ram_data} !== {8'h20, 1'b1, 32'h0000_0034}) begin
      tests_failed++;
      $display("FAIL hstore_b0: addr=%h wren=%b data=%h exp 20 1 34", ram_address, ram_wren, ram_data);
    end
    tick();
    tests_run++;
    if ({ram_address, ram_wren, ram_data, bus.rsp_valid} !== {8'h21, 1'b1, 32'h0000_0012, 1'b0}) begin
      tests_failed++;
      $display("FAIL hstore_b1: addr=%h wren=%b data=%h rv=%b exp 21 1 12 0", ram_address,
               ram_wren, ram_data, bus.rsp_valid);
    end
    tick();
    tests_run++;
    if ({bus.rsp_valid, ram_wren, bus.rsp_rdata} !== {2'b10, 32'h0}) begin
      tests_failed++;
      $display("FAIL hstore_rsp: rv=%b wren=%b rd=%h exp 1 0 0", bus.rsp_valid, ram_wren, bus.rsp_rdata);
    end
    tick();
    tests_run++;
    if ({mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]} !== 32'h3412_0000) begin
      tests_failed++;
      $display("FAIL hstore_mem: %h %h %h %h exp 34 12 00 00", mem[8'h20], mem[8'h21],
               mem[8'h22], mem[8'h23]);
    end
  endtask

  task automatic test_byte_load();
    // 0x30=C1, 0x31=77: the byte load must not pull in 0x31
    send(1'b1, 2'b01, 8'h30, 32'h0000_77C1);
    tick(); tick(); tick();
    send(1'b0, 2'b00, 8'h30, 32'h0);
    tests_run++;
    if ({ram_address, ram_wren, bus.rsp_valid} !== {8'h30, 2'b00}) begin
      tests_failed++;
      $display("FAIL bload_addr: addr=%h wren=%b rv=%b exp 30 0 0", ram_address, ram_wren, bus.rsp_valid);
    end
    tick();
    tests_run++;
    if (bus.rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bload_early: rv=%b exp 0", bus.rsp_valid);
    end
    tick();
    tests_run++;
    if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 32'h0000_00C1}) begin
      tests_failed++;
      $display("FAIL bload_rsp: rv=%b rd=%h exp 1 000000c1", bus.rsp_valid, bus.rsp_rdata);
    end
    tick();
  endtask

  task automatic test_wrap();
    logic [7:0] ea [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    logic [7:0] ed [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
    send(1'b1, 2'b10, 8'hFE, 32'h1122_3344);
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if ({ram_address, ram_wren, ram_data} !== {ea[k], 1'b1, 24'h0, ed[k]}) begin
        tests_failed++;
        $display("FAIL wrap_store%0d: addr=%h wren=%b data=%h exp %h 1 %h", k, ram_address,
                 ram_wren, ram_data, ea[k], ed[k]);
      end
      tick();
    end
    tick();
    // reserved size code behaves as a word
    send(1'b0, 2'b11, 8'hFE, 32'h0);
    tick(); tick(); tick(); tick();
    tests_run++;
    if (bus.rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_load_early: rv=%b exp 0", bus.rsp_valid);
    end
    tick();
    tests_run++;
    if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 32'h1122_3344}) begin
      tests_failed++;
      $display("FAIL wrap_load: rv=%b rd=%h exp 1 11223344", bus.rsp_valid, bus.rsp_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int rsp_seen = 0;
    send(1'b1, 2'b10, 8'h40, 32'hCAFE_F00D);
    tick();
    // reset is sampled on the edge that ends the cycle presenting 0x41
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if ({ram_wren, bus.req_ready, bus.rsp_valid, ram_address} !== {3'b010, 8'h00}) begin
      tests_failed++;
      $display("FAIL rstmid_state: wren=%b rdy=%b rv=%b addr=%h exp 0 1 0 00", ram_wren,
               bus.req_ready, bus.rsp_valid, ram_address);
    end
    for (int k = 0; k < 6; k++) begin
      if (bus.rsp_valid === 1'b1) rsp_seen++;
      tick();
    end
    tests_run++;
    if (rsp_seen != 0) begin
      tests_failed++;
      $display("FAIL rstmid_norsp: rsp pulses=%0d exp 0", rsp_seen);
    end
    tests_run++;
    if ({mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]} !== 32'h0DF0_0000) begin
      tests_failed++;
      $display("FAIL rstmid_mem: %h %h %h %h exp 0d f0 00 00", mem[8'h40], mem[8'h41],
               mem[8'h42], mem[8'h43]);
    end
  endtask

  task automatic test_back_to_back();
    int bad_ready = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = 8'h50;
    bus.req_wdata = 32'h0102_0304;
    tick();
    bus.req_size  = 2'b01;
    bus.req_addr  = 8'h60;
    bus.req_wdata = 32'hBBBB_5678;
    for (int k = 0; k < 4; k++) begin
      if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0) bad_ready++;
      tick();
    end
    tests_run++;
    if (bad_ready != 0 || {bus.rsp_valid, bus.req_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL b2b_first: early rdy/rsp cycles=%0d rv=%b rdy=%b exp 0 1 0", bad_ready,
               bus.rsp_valid, bus.req_ready);
    end
    tick();
    tests_run++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL b2b_gap: rv=%b rdy=%b exp 0 1", bus.rsp_valid, bus.req_ready);
    end
    tick();
    bus.req_valid = 1'b0;
    tests_run++;
    if ({ram_address, ram_wren, ram_data, bus.req_ready} !== {8'h60, 1'b1, 32'h0000_0078, 1'b0}) begin
      tests_failed++;
      $display("FAIL b2b_second: addr=%h wren=%b data=%h rdy=%b exp 60 1 78 0", ram_address,
               ram_wren, ram_data, bus.req_ready);
    end
    tick();
    tick();
    tests_run++;
    if (bus.rsp_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_rsp2: rv=%b exp 1", bus.rsp_valid);
    end
    tick();
    tests_run++;
    if ({mem[8'h50], mem[8'h51], mem[8'h52], mem[8'h53], mem[8'h60], mem[8'h61], mem[8'h62]}
        !== 56'h0403_0201_7856_00) begin
      tests_failed++;
      $display("FAIL b2b_mem: %h %h %h %h %h %h %h exp 04 03 02 01 78 56 00", mem[8'h50],
               mem[8'h51], mem[8'h52], mem[8'h53], mem[8'h60], mem[8'h61], mem[8'h62]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b00;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 32'h0;
    tick();
    test_reset();
    test_word_store();
    test_word_load();
    test_half_store();
    test_byte_load();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
